// File: rtl/mux_serial_port_if.sv
// CPU6 external-bus view of the serial port: address, write data and strobes in,
// read data and the window-select flag back out to the bus mux.
interface mux_serial_port_if;
  logic [15:0] addressBus;
  logic [7:0]  dataOutBus;
  logic        writeEnBus;
  logic        readEnBus;
  logic [7:0]  dataInBus;
  logic        selected;

  modport master (
    output addressBus, dataOutBus, writeEnBus, readEnBus,
    input  dataInBus, selected
  );

  modport slave (
    input  addressBus, dataOutBus, writeEnBus, readEnBus,
    output dataInBus, selected
  );
endinterface

// File: rtl/mux_serial_port.sv
// Memory-mapped 8N1 UART on the CPU6 bus: STATUS/DATA/CONTROL registers, a
// holding+shift transmitter, a mid-bit-sampling receiver and a level irq.
module mux_serial_port #(
  parameter logic [15:0] BASE_ADDR    = 16'hF200,
  parameter int          CLKS_PER_BIT = 434
) (
  input  logic              clock,
  input  logic              reset,
  mux_serial_port_if.slave  bus,
  input  logic              rxd,
  output logic              txd,
  output logic              irq
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d, hold_q, hold_d;
  logic [7:0]       rx_shift_q, rx_shift_d, rx_buf_q, rx_buf_d;
  logic             hold_full_q, hold_full_d, txd_q, txd_d;
  logic             rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic             rx_err_q, rx_err_d, rx_full_q, rx_full_d;
  logic             overrun_q, overrun_d, framing_q, framing_d;
  logic             rxie_q, rxie_d, txie_q, txie_d, irq_q, irq_d;
  logic             tx_load, rx_done, frame_set;

  logic [1:0] offset;
  logic       wr_data, wr_ctrl, rd_data, rd_status;

  assign offset       = bus.addressBus[1:0];
  assign bus.selected = (bus.addressBus[15:2] == BASE_ADDR[15:2]);
  assign wr_data      = bus.writeEnBus & bus.selected & (offset == 2'd1);
  assign wr_ctrl      = bus.writeEnBus & bus.selected & (offset == 2'd2);
  assign rd_data      = bus.readEnBus  & bus.selected & (offset == 2'd1);
  assign rd_status    = bus.readEnBus  & bus.selected & (offset == 2'd0);

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    txd_d       = txd_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_load     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (hold_full_q) tx_load = 1'b1;
      end
      S_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
          txd_d      = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (hold_full_q) tx_load = 1'b1;
          else tx_state_d = S_IDLE;
        end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_load) begin
      tx_shift_d  = hold_q;
      hold_full_d = 1'b0;
      tx_state_d  = S_START;
      tx_cnt_d    = '0;
      txd_d       = 1'b0;
    end
    // The transfer empties the holding register, so a write on that same edge is accepted.
    if (wr_data && (!hold_full_q || tx_load)) begin
      hold_d      = bus.dataOutBus;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    rx_meta_d  = rxd;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_err_d   = rx_err_q;
    rx_done    = 1'b0;
    frame_set  = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
      S_STOP: begin
        // After a bad stop bit, hold here until the line returns high.
        if (rx_err_q) begin
          if (rx_sync_q) begin
            rx_err_d   = 1'b0;
            rx_state_d = S_IDLE;
          end
        end else if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_done    = 1'b1;
            rx_state_d = S_IDLE;
          end else begin
            rx_err_d  = 1'b1;
            frame_set = 1'b1;
          end
        end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_buf_d  = rx_buf_q;
    rx_full_d = rx_full_q;
    overrun_d = overrun_q;
    framing_d = framing_q;
    rxie_d    = rxie_q;
    txie_d    = txie_q;
    if (rd_data) rx_full_d = 1'b0;
    if (rd_status) begin
      overrun_d = 1'b0;
      framing_d = 1'b0;
    end
    if (rx_done) begin
      if (rx_full_q && !rd_data) overrun_d = 1'b1;
      else begin
        rx_buf_d  = rx_shift_q;
        rx_full_d = 1'b1;
      end
    end
    if (frame_set) framing_d = 1'b1;
    if (wr_ctrl) begin
      rxie_d = bus.dataOutBus[0];
      txie_d = bus.dataOutBus[1];
    end
    irq_d = (rx_full_q & rxie_q) | (!hold_full_q & txie_q);
  end

  always_comb begin
    bus.dataInBus = 8'h00;
    if (bus.selected) begin
      case (offset)
        2'd0:    bus.dataInBus = {4'b0, framing_q, overrun_q, !hold_full_q, rx_full_q};
        2'd1:    bus.dataInBus = rx_buf_q;
        2'd2:    bus.dataInBus = {6'b0, txie_q, rxie_q};
        default: bus.dataInBus = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= S_IDLE;  rx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;      rx_cnt_q   <= '0;
      tx_bit_q   <= '0;      rx_bit_q   <= '0;
      tx_shift_q <= '0;      rx_shift_q <= '0;
      hold_q     <= '0;      hold_full_q <= 1'b0;
      txd_q      <= 1'b1;    rx_buf_q   <= '0;
      rx_meta_q  <= 1'b1;    rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;    rx_err_q   <= 1'b0;
      rx_full_q  <= 1'b0;    overrun_q  <= 1'b0;
      framing_q  <= 1'b0;    rxie_q     <= 1'b0;
      txie_q     <= 1'b0;    irq_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;  rx_state_q <= rx_state_d;
      tx_cnt_q   <= tx_cnt_d;    rx_cnt_q   <= rx_cnt_d;
      tx_bit_q   <= tx_bit_d;    rx_bit_q   <= rx_bit_d;
      tx_shift_q <= tx_shift_d;  rx_shift_q <= rx_shift_d;
      hold_q     <= hold_d;      hold_full_q <= hold_full_d;
      txd_q      <= txd_d;       rx_buf_q   <= rx_buf_d;
      rx_meta_q  <= rx_meta_d;   rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;   rx_err_q   <= rx_err_d;
      rx_full_q  <= rx_full_d;   overrun_q  <= overrun_d;
      framing_q  <= framing_d;   rxie_q     <= rxie_d;
      txie_q     <= txie_d;      irq_q      <= irq_d;
    end
  end

  assign txd = txd_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_mux_serial_port.sv
// Directed bench for mux_serial_port with a fast bit rate; transmitted and
// received bytes are tracked in scoreboard queues and checked as they appear.
module tb_mux_serial_port;
  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset;
  logic rxd;
  logic txd;
  logic irq;

  mux_serial_port_if bus ();

  mux_serial_port #(.BASE_ADDR(16'hF200), .CLKS_PER_BIT(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .rxd   (rxd),
    .txd   (txd),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  logic [7:0] txQueue[$];
  logic [7:0] rxQueue[$];

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data, input logic we, input logic re);
    bus.addressBus = addr;
    bus.dataOutBus = data;
    bus.writeEnBus = we;
    bus.readEnBus  = re;
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [7:0] data);
    applyStimulus(addr, data, 1'b1, 1'b0);
    @(negedge clock);
    applyStimulus(addr, data, 1'b0, 1'b0);
  endtask

  task automatic busRead(input logic [15:0] addr, output logic [7:0] data);
    applyStimulus(addr, 8'h00, 1'b0, 1'b1);
    #1 data = bus.dataInBus;
    @(negedge clock);
    applyStimulus(addr, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic peek(input logic [15:0] addr, output logic [7:0] data);
    applyStimulus(addr, 8'h00, 1'b0, 1'b0);
    #1 data = bus.dataInBus;
  endtask

  task automatic sendRxFrame(input logic [7:0] value, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, value, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (CPB) @(negedge clock);
    end
    rxd = 1'b1;
  endtask

  // skip < 0 waits for the start bit; otherwise it is the current offset into the frame.
  task automatic checkTxFrame(input int skip, input logic nextLow, input string tag);
    int cur;
    int waited;
    logic [9:0] got;
    logic [7:0] expByte;
    cur = skip;
    if (skip < 0) begin
      waited = 0;
      while (txd !== 1'b0 && waited < 200) begin
        @(negedge clock);
        waited++;
      end
      checkOutput({tag, "_start"}, 16'(txd), 16'h0);
      cur = 0;
    end
    for (int i = 0; i < 10; i++) begin
      while (cur < i * CPB + CPB / 2) begin
        @(negedge clock);
        cur++;
      end
      got[i] = txd;
    end
    if (txQueue.size() > 0) expByte = txQueue.pop_front();
    else expByte = 8'hxx;
    checkOutput({tag, "_frame"}, 16'(got), 16'({1'b1, expByte, 1'b0}));
    while (cur < 10 * CPB) begin
      @(negedge clock);
      cur++;
    end
    checkOutput({tag, "_after"}, 16'(txd), 16'(!nextLow));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    logic [9:0] frame;
    logic [7:0] expByte;
    int lows;

    rxd = 1'b1;
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state and address decode
    checkOutput("resetTxd", 16'(txd), 16'h1);
    checkOutput("resetIrq", 16'(irq), 16'h0);
    busRead(16'hF200, rd);
    checkOutput("resetStatus", 16'(rd), 16'h02);
    busRead(16'hF203, rd);
    checkOutput("reg3Read", 16'(rd), 16'h00);
    peek(16'hF204, rd);
    checkOutput("outsideSelected", 16'(bus.selected), 16'h0);
    checkOutput("outsideData", 16'(rd), 16'h00);
    peek(16'hF201, rd);
    checkOutput("insideSelected", 16'(bus.selected), 16'h1);

    // CONTROL register and the one-cycle irq lag
    @(negedge clock);
    busWrite(16'hF202, 8'hFD);
    busRead(16'hF202, rd);
    checkOutput("controlRead", 16'(rd), 16'h01);
    busWrite(16'hF202, 8'h02);
    checkOutput("txieIrqLag", 16'(irq), 16'h0);
    @(negedge clock);
    checkOutput("txieIrq", 16'(irq), 16'h1);
    busWrite(16'hF202, 8'h00);
    checkOutput("txieOffLag", 16'(irq), 16'h1);
    @(negedge clock);
    checkOutput("txieOff", 16'(irq), 16'h0);

    // Single frame 8'hA5, checked on every cycle
    busWrite(16'hF201, 8'hA5);
    txQueue.push_back(8'hA5);
    peek(16'hF200, rd);
    checkOutput("txReadyLow", 16'(rd), 16'h00);
    @(negedge clock);
    peek(16'hF200, rd);
    checkOutput("txReadyBack", 16'(rd), 16'h02);
    expByte = txQueue.pop_front();
    frame = {1'b1, expByte, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        checkOutput($sformatf("txA5bit%0d", i), 16'(txd), 16'(frame[i]));
        @(negedge clock);
      end
    end
    checkOutput("txA5idle", 16'(txd), 16'h1);

    // Back-to-back frames; 8'h33 hits a full holding register and is dropped
    busWrite(16'hF201, 8'h11);
    txQueue.push_back(8'h11);
    busWrite(16'hF201, 8'h22);
    txQueue.push_back(8'h22);
    busWrite(16'hF201, 8'h33);
    checkTxFrame(1, 1'b1, "tx11");
    checkTxFrame(0, 1'b0, "tx22");
    lows = 0;
    repeat (60) begin
      @(negedge clock);
      if (txd !== 1'b1) lows++;
    end
    checkOutput("tx33Dropped", 16'(lows), 16'h0);

    // Receive 8'h3C with RXIE
    sendRxFrame(8'h3C, 1'b1);
    rxQueue.push_back(8'h3C);
    peek(16'hF200, rd);
    checkOutput("rxLatencyBefore", 16'(rd), 16'h02);
    @(negedge clock);
    peek(16'hF200, rd);
    checkOutput("rxFullStatus", 16'(rd), 16'h03);
    @(negedge clock);
    busWrite(16'hF202, 8'h01);
    checkOutput("rxieIrqLag", 16'(irq), 16'h0);
    @(negedge clock);
    checkOutput("rxieIrq", 16'(irq), 16'h1);
    busRead(16'hF201, rd);
    if (rxQueue.size() > 0) expByte = rxQueue.pop_front();
    else expByte = 8'hxx;
    checkOutput("rxData3C", 16'(rd), 16'(expByte));
    peek(16'hF200, rd);
    checkOutput("rxClearedStatus", 16'(rd), 16'h02);
    @(negedge clock);
    checkOutput("rxIrqCleared", 16'(irq), 16'h0);

    // Overrun: second byte arrives before the first is read
    sendRxFrame(8'h01, 1'b1);
    rxQueue.push_back(8'h01);
    repeat (4) @(negedge clock);
    sendRxFrame(8'h02, 1'b1);
    repeat (4) @(negedge clock);
    peek(16'hF200, rd);
    checkOutput("overrunStatus", 16'(rd), 16'h07);
    busRead(16'hF201, rd);
    if (rxQueue.size() > 0) expByte = rxQueue.pop_front();
    else expByte = 8'hxx;
    checkOutput("overrunKeepsOld", 16'(rd), 16'(expByte));
    busRead(16'hF200, rd);
    checkOutput("overrunRead", 16'(rd), 16'h06);
    peek(16'hF200, rd);
    checkOutput("overrunCleared", 16'(rd), 16'h02);

    // Framing error, then a one-cycle glitch, then a good byte
    @(negedge clock);
    sendRxFrame(8'h55, 1'b0);
    repeat (4) @(negedge clock);
    peek(16'hF200, rd);
    checkOutput("framingStatus", 16'(rd), 16'h0A);
    busRead(16'hF200, rd);
    peek(16'hF200, rd);
    checkOutput("framingCleared", 16'(rd), 16'h02);
    @(negedge clock);
    rxd = 1'b0;
    @(negedge clock);
    rxd = 1'b1;
    repeat (10) @(negedge clock);
    peek(16'hF200, rd);
    checkOutput("glitchNoFlags", 16'(rd), 16'h02);
    @(negedge clock);
    sendRxFrame(8'h5A, 1'b1);
    rxQueue.push_back(8'h5A);
    repeat (4) @(negedge clock);
    busRead(16'hF201, rd);
    if (rxQueue.size() > 0) expByte = rxQueue.pop_front();
    else expByte = 8'hxx;
    checkOutput("rxAfterGlitch", 16'(rd), 16'(expByte));

    // Reset in the middle of a transmitted frame
    busWrite(16'hF201, 8'h00);
    repeat (3 * CPB) @(negedge clock);
    checkOutput("txMidFrame", 16'(txd), 16'h0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("txResetAbort", 16'(txd), 16'h1);
    reset = 1'b0;
    peek(16'hF200, rd);
    checkOutput("statusAfterReset", 16'(rd), 16'h02);
    lows = 0;
    repeat (60) begin
      @(negedge clock);
      if (txd !== 1'b1) lows++;
    end
    checkOutput("txQuietAfterReset", 16'(lows), 16'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
